hazard_fwd_ctrl: RTL and testbench

//  Parametrised hazard/forwarding controller for the RISC-V pipeline; successor to the combinational forwarding unit.

---
 rtl/hazard_fwd_ctrl_pkg.sv | 21 ++
 rtl/hazard_fwd_ctrl_fwd_match_prio.sv | 38 +++
 rtl/hazard_fwd_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared constants for the hazard/forwarding controller: register index width,
// in-flight tag layout and the regfile select encoding.
package hazard_fwd_ctrl_pkg;

  localparam int unsigned REG_ADDR_WIDTH_DEF = 5;
  localparam int unsigned FWD_SEL_REGFILE    = 0;

  // Tag layout, LSB first: is_load, wr_en, rd[REG_ADDR_WIDTH], valid
  localparam int unsigned TAG_LD_BIT = 0;
  localparam int unsigned TAG_WE_BIT = 1;
  localparam int unsigned TAG_RD_LSB = 2;

  function automatic int unsigned tag_width(input int unsigned reg_addr_width);
    return reg_addr_width + 3;
  endfunction

  function automatic int unsigned tag_valid_bit(input int unsigned reg_addr_width);
    return reg_addr_width + 2;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_match_prio.sv
// Priority match of one source register against the in-flight destination tags.
// Reports whether any stage matches, the youngest matching stage and whether it is a load.
module fwd_match_prio
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int unsigned FWD_DEPTH      = 3,
  localparam int unsigned TAG_W         = REG_ADDR_WIDTH + 3,
  localparam int unsigned K_W           = $clog2(FWD_DEPTH)
) (
  input  logic [REG_ADDR_WIDTH-1:0]  rs,
  input  logic                       rs_used,
  input  logic [FWD_DEPTH*TAG_W-1:0] tags,
  output logic                       hit,
  output logic [K_W-1:0]             k,
  output logic                       is_load
);

  localparam int unsigned VLD_BIT = tag_valid_bit(REG_ADDR_WIDTH);

  // Scan oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    hit     = 1'b0;
    k       = '0;
    is_load = 1'b0;
    for (int i = int'(FWD_DEPTH) - 1; i >= 0; i--) begin
      if (rs_used && (rs != '0) &&
          tags[i*TAG_W + VLD_BIT] &&
          tags[i*TAG_W + TAG_WE_BIT] &&
          (tags[i*TAG_W + TAG_RD_LSB +: REG_ADDR_WIDTH] == rs)) begin
        hit     = 1'b1;
        k       = K_W'(i);
        is_load = tags[i*TAG_W + TAG_LD_BIT];
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: shadow tags of in-flight instructions, registered EX
// forward selects, combinational ID branch-compare selects and load-use/branch stall.
// Optional HAZ_PERF_CNT_EN adds saturating stall and load-use stall counters.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned FWD_DEPTH      = 3,
  parameter int unsigned LOAD_STAGE     = 2,
  localparam int unsigned SEL_WIDTH     = $clog2(FWD_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_valid,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [NUM_SRC-1:0]                id_rs_used,
  input  logic [REG_ADDR_WIDTH-1:0]         id_rd,
  input  logic                              id_reg_wr_en,
  input  logic                              id_is_load,
  input  logic                              id_is_branch,
  input  logic                              flush,
  output logic                              stall,
  output logic [NUM_SRC*SEL_WIDTH-1:0]      fwd_sel,
  output logic [2*SEL_WIDTH-1:0]            cmp_sel
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_stall_cnt,
  output logic [31:0]                       perf_lu_cnt
`endif
);

  localparam int unsigned TAG_W   = tag_width(REG_ADDR_WIDTH);
  localparam int unsigned VLD_BIT = tag_valid_bit(REG_ADDR_WIDTH);

  if (NUM_SRC < 2) begin : g_bad_num_src
    $error("hazard_fwd_ctrl: NUM_SRC must be >= 2");
  end
  if (FWD_DEPTH < 2) begin : g_bad_depth
    $error("hazard_fwd_ctrl: FWD_DEPTH must be >= 2");
  end
  if ((LOAD_STAGE < 1) || (LOAD_STAGE > FWD_DEPTH - 1)) begin : g_bad_load_stage
    $error("hazard_fwd_ctrl: LOAD_STAGE must be in 1..FWD_DEPTH-1");
  end

  logic [FWD_DEPTH*TAG_W-1:0]     shadow_q;
  logic [TAG_W-1:0]               stage0_d;
  logic [NUM_SRC*SEL_WIDTH-1:0]   fwd_sel_d;
  logic [NUM_SRC-1:0]             src_hit;
  logic [NUM_SRC-1:0]             src_ld;
  logic [SEL_WIDTH-1:0]           src_k [NUM_SRC];
  logic [NUM_SRC-1:0]             lu_haz;
  logic                           br_haz;
  logic                           advance;

  for (genvar s = 0; s < int'(NUM_SRC); s++) begin : g_src
    fwd_match_prio #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .FWD_DEPTH      (FWD_DEPTH)
    ) u_match (
      .rs      (id_rs[s*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
      .rs_used (id_rs_used[s]),
      .tags    (shadow_q),
      .hit     (src_hit[s]),
      .k       (src_k[s]),
      .is_load (src_ld[s])
    );
  end

  // EX forward selects and load-use detection, one source at a time
  always_comb begin
    fwd_sel_d = '0;
    lu_haz    = '0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      if (src_hit[s]) begin
        if (src_ld[s] && ((32'(src_k[s]) + 32'd1) < LOAD_STAGE)) begin
          lu_haz[s] = 1'b1;
        end else if (32'(src_k[s]) <= (FWD_DEPTH - 2)) begin
          fwd_sel_d[s*SEL_WIDTH +: SEL_WIDTH] = src_k[s] + SEL_WIDTH'(1);
        end else begin
          fwd_sel_d[s*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(FWD_SEL_REGFILE);
        end
      end
    end
  end

  // Branch compare in ID reads the value a stage holds now, not one cycle later
  always_comb begin
    br_haz  = 1'b0;
    cmp_sel = '0;
    if (id_is_branch) begin
      for (int s = 0; s < 2; s++) begin
        if (src_hit[s]) begin
          if (src_ld[s] ? (32'(src_k[s]) < LOAD_STAGE) : (src_k[s] == '0)) begin
            br_haz = 1'b1;
          end else begin
            cmp_sel[s*SEL_WIDTH +: SEL_WIDTH] = src_k[s];
          end
        end
      end
    end
  end

  always_comb begin
    stall   = id_valid & ~flush & ((|lu_haz) | br_haz);
    advance = id_valid & ~stall & ~flush;
    stage0_d = '0;
    if (advance) begin
      stage0_d[VLD_BIT]                        = 1'b1;
      stage0_d[TAG_RD_LSB +: REG_ADDR_WIDTH]   = id_rd;
      stage0_d[TAG_WE_BIT]                     = id_reg_wr_en;
      stage0_d[TAG_LD_BIT]                     = id_is_load;
    end
  end

  // Shadow shift register (stage 0 in the low tag slot) and the EX select register
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      fwd_sel  <= '0;
    end else begin
      shadow_q <= {shadow_q[(FWD_DEPTH-1)*TAG_W-1:0], stage0_d};
      fwd_sel  <= advance ? fwd_sel_d : '0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic lu_stall;
  assign lu_stall = id_valid & ~flush & (|lu_haz);

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_lu_cnt    <= '0;
    end else begin
      if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (lu_stall && (perf_lu_cnt != 32'hFFFF_FFFF)) begin
        perf_lu_cnt <= perf_lu_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: a driver issues one vector per cycle and queues its
// hand-computed expectations; a monitor pops and compares on the falling edge.
module tb_hazard_fwd_ctrl;

  localparam int D = -1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [9:0]  id_rs = '0;
  logic [1:0]  id_rs_used = '0;
  logic [4:0]  id_rd = '0;
  logic        id_reg_wr_en = 1'b0;
  logic        id_is_load = 1'b0;
  logic        id_is_branch = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [3:0]  cmp_sel;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_lu_cnt;
`endif

  hazard_fwd_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .id_rd        (id_rd),
    .id_reg_wr_en (id_reg_wr_en),
    .id_is_load   (id_is_load),
    .id_is_branch (id_is_branch),
    .flush        (flush),
    .stall        (stall),
    .fwd_sel      (fwd_sel),
    .cmp_sel      (cmp_sel)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_lu_cnt    (perf_lu_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    bit    r, vl;
    int    rs0, rs1, used, rd;
    bit    we, ld, br, fl;
    int    es, ef0, ef1, ec0, ec1, eps, epl;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic v(input string nm, input bit r, input bit vl, input int rs0, input int rs1,
                   input int used, input int rd, input bit we, input bit ld, input bit br,
                   input bit fl, input int es, input int ef0, input int ef1, input int ec0,
                   input int ec1);
    vec_t t;
    t.nm = nm; t.r = r; t.vl = vl; t.rs0 = rs0; t.rs1 = rs1; t.used = used; t.rd = rd;
    t.we = we; t.ld = ld; t.br = br; t.fl = fl;
    t.es = es; t.ef0 = ef0; t.ef1 = ef1; t.ec0 = ec0; t.ec1 = ec1; t.eps = D; t.epl = D;
    vecs.push_back(t);
  endtask

  task automatic perf_exp(input int ps, input int pl);
    vecs[vecs.size()-1].eps = ps;
    vecs[vecs.size()-1].epl = pl;
  endtask

  task automatic idle(input string nm, input int es, input int ef0, input int ef1);
    v(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, es, ef0, ef1, 0, 0);
  endtask

  task automatic chk(input string nm, input string fld, input int got, input int want);
    if (want >= 0) begin
      n_cmp++;
      if (got != want) begin
        n_fail++;
        $display("FAIL %s.%s cycle %0d: got %0d, expected %0d", nm, fld, cyc, got, want);
      end
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation for this cycle
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.nm, "stall",  int'(stall),        e.es);
        chk(e.nm, "fwd0",   int'(fwd_sel[1:0]), e.ef0);
        chk(e.nm, "fwd1",   int'(fwd_sel[3:2]), e.ef1);
        chk(e.nm, "cmp0",   int'(cmp_sel[1:0]), e.ec0);
        chk(e.nm, "cmp1",   int'(cmp_sel[3:2]), e.ec1);
`ifdef HAZ_PERF_CNT_EN
        chk(e.nm, "pstall", int'(perf_stall_cnt), e.eps);
        chk(e.nm, "plu",    int'(perf_lu_cnt),    e.epl);
`endif
        cyc++;
      end
    end
  end

  // Driver
  initial begin
    //  name              r vl rs0 rs1 u rd we ld br fl  st f0 f1 c0 c1
    v("reset",            1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  D, D, D, D, D);
    idle("reset_state",   0, 0, 0);                         perf_exp(0, 0);
    v("add5",             0, 1, 1, 2, 3, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    v("add6_x5x5",        0, 1, 5, 5, 3, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    idle("b2b_fwd",       0, 1, 1);
    v("add5_b",           0, 1, 1, 2, 3, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    idle("nop",           0, 0, 0);
    v("sub7_x5x1",        0, 1, 5, 1, 3, 7, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    idle("gap1_fwd",      0, 2, 0);
    v("add5_c",           0, 1, 1, 2, 3, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    idle("nop_a",         0, 0, 0);
    idle("nop_b",         0, 0, 0);
    v("add8_x5x5",        0, 1, 5, 5, 3, 8, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    idle("gap2_regfile",  0, 0, 0);
    v("lw5",              0, 1, 1, 0, 1, 5, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    v("lu_stall",         0, 1, 5, 3, 3, 6, 1, 0, 0, 0,  1, 0, 0, 0, 0);
    v("lu_bubble",        0, 1, 5, 3, 3, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0); perf_exp(1, 1);
    idle("lu_fwd",        0, 2, 0);
    v("add5_d",           0, 1, 1, 2, 3, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    v("beq_alu_stall",    0, 1, 5, 0, 3, 0, 0, 0, 1, 0,  1, 0, 0, D, D);
    v("beq_alu_cmp",      0, 1, 5, 0, 3, 0, 0, 0, 1, 0,  0, 0, 0, 1, 0); perf_exp(2, 1);
    idle("beq_in_ex",     0, 2, 0);
    v("lw5_b",            0, 1, 1, 0, 1, 5, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    v("beq_lw_stall1",    0, 1, 5, 0, 3, 0, 0, 0, 1, 0,  1, 0, 0, D, D);
    v("beq_lw_stall2",    0, 1, 5, 0, 3, 0, 0, 0, 1, 0,  1, 0, 0, D, D);
    v("beq_lw_cmp",       0, 1, 5, 0, 3, 0, 0, 0, 1, 0,  0, 0, 0, 2, 0); perf_exp(4, 2);
    idle("after_beq",     0, 0, 0);
    v("lw_x0",            0, 1, 1, 0, 1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    v("beq_x0x0",         0, 1, 0, 0, 3, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    v("lw9",              0, 1, 1, 0, 1, 9, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    v("rs_unused",        0, 1, 9, 9, 0, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    idle("rs_unused_ex",  0, 0, 0);
    v("lw5_c",            0, 1, 1, 0, 1, 5, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    v("lu_flush",         0, 1, 5, 5, 3, 6, 1, 0, 0, 1,  0, 0, 0, 0, 0);
    idle("flush_bubble",  0, 0, 0);
    v("add5_e",           0, 1, 1, 2, 3, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    v("lw6_x5",           0, 1, 5, 0, 1, 6, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    v("rst_mid_stall",    1, 1, 6, 6, 3, 7, 1, 0, 0, 0,  1, 1, 0, 0, 0); perf_exp(4, 2);
    v("post_rst",         0, 1, 6, 5, 3, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0); perf_exp(0, 0);
    idle("post_rst_ex",   0, 0, 0);
    v("lw5_d",            0, 1, 1, 0, 1, 5, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    v("lu_stall_b",       0, 1, 5, 0, 1, 6, 1, 0, 0, 0,  1, 0, 0, 0, 0);
    idle("count_resume",  0, 0, 0);                         perf_exp(1, 1);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst          = vecs[i].r;
      id_valid     = vecs[i].vl;
      id_rs        = {5'(vecs[i].rs1), 5'(vecs[i].rs0)};
      id_rs_used   = 2'(vecs[i].used);
      id_rd        = 5'(vecs[i].rd);
      id_reg_wr_en = vecs[i].we;
      id_is_load   = vecs[i].ld;
      id_is_branch = vecs[i].br;
      flush        = vecs[i].fl;
      sb.push_back(vecs[i]);
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
